dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised, handshaked data memory for the RISC-V datapath. It replaces the fixed 64-word, combinational-read, write-only-sized data memory. It adds configurable depth and read latency, a valid/ready request port, sized and sign- or zero-extended loads, and misalignment/illegal-size error reporting. It sits between the execute stage (or the cache refill path) and the register-file writeback mux.

## Interface
- N_Bits, 32: data and address width. Only 32 is supported.
- Depth, 256: number of N_Bits words. Must be a power of 2, ≥ 4.
- Latency, 1: cycles from request accept to rsp_valid. Legal range 1..4.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0). Ignored on stores.
- A  in  N_Bits  byte address.
- WD  in  N_Bits  store data; the low byte/half is used for sub-word stores.
- rsp_valid  out  1  response strobe, exactly one cycle wide.
- RD  out  N_Bits  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-size request; qualified by rsp_valid.

## Operation
- Word index = A[log2(Depth)+1:2]. Higher address bits are ignored, so addresses wrap modulo Depth*4. Lane = A[1:0].
- Error condition: size 11; half with A[0]=1; word with A[1:0]≠00. An errored request is accepted normally. It writes nothing, and its response carries rsp_err=1 and RD=0.
- Stores:
  - Byte store writes WD[7:0] into lane A[1:0].
  - Half store writes WD[15:0] into lanes {A[1],0} and {A[1],1}.
  - Word store writes all lanes.
  - Untouched lanes keep their old value.
  - The write commits on the accept edge.
- Loads:
  - The addressed word is captured on the accept edge.
  - The byte or half is selected by lane, then extended to 32 bits per req_unsigned.
  - Word loads are passed through unchanged.
- Memory contents are not reset. Simulation initial contents are undefined unless preloaded by the bench.
- FSM:
  - IDLE: req_ready=1. On req_valid, accept, load cnt=Latency-1, go to WAIT.
  - WAIT: req_ready=0. If cnt≠0, decrement. If cnt=0, assert rsp_valid with RD/rsp_err and go to IDLE.
- Only one request is outstanding at a time. There is no response backpressure; the consumer must take rsp_valid when it is asserted.

## Timing
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE; rsp_valid=0; RD=0; rsp_err=0; cnt=0; state IDLE.
- Accept at edge T (req_valid=1 and req_ready=1). rsp_valid is high in the cycle after edge T+Latency-1, which is Latency cycles after accept.
- req_ready is low from the cycle after accept through the rsp_valid cycle inclusive.
- Back-to-back issue rate is one request per Latency+1 cycles.
- RD and rsp_err are registered. They hold their value outside rsp_valid, and consumers must ignore them then.
- A load following a store to the same word returns the new data, because the store committed before the load was accepted.
- rst asserted in a cycle with req_valid=1: reset wins; no accept and no write.
- rst asserted while in WAIT:
  - Return to IDLE.
  - No rsp_valid is issued for the in-flight request.
  - A store from that request stays committed.
- Inputs other than req_valid are sampled only on the accept edge. They may change freely while in WAIT.

## Test plan
- Word store then load with Latency=1: store 0xDEADBEEF @0x10 is accepted; rsp_valid arrives 1 cycle later with err=0. A load @0x10 returns RD=0xDEADBEEF, and req_ready is low for exactly 1 cycle after each accept.
- Byte stores and extended loads:
  - Store 0x80 @0x21 into word 0x11223344 → word reads 0x11228044.
  - Signed byte load @0x21 → 0xFFFFFF80.
  - Unsigned byte load @0x21 → 0x00000080.
  - Signed half load @0x22 → 0x00001122.
- Misalignment and illegal size:
  - Half store @0x03 → rsp_err=1, RD=0, memory unchanged.
  - Word load @0x06 → rsp_err=1.
  - Size 11 @0x00 → rsp_err=1.
- Latency=4 with req_valid held high continuously: rsp_valid arrives 4 cycles after each accept, and accepts are spaced 5 cycles apart.
- Wrap-around with Depth=256: store 0xA5A5A5A5 @0x400; a load @0x000 returns 0xA5A5A5A5.
- Reset mid-operation with Latency=3:
  - Load accepted, rst pulsed on the following cycle → no rsp_valid ever appears for it; req_ready=1 on the cycle after rst deasserts.
  - Store accepted then reset → a later load shows the stored value.

Source files
------------

// File: rtl/dmem_lsu.sv
// Handshaked data memory with configurable depth and read latency. Supports sized
// stores and sign/zero-extended loads, and reports misaligned or illegal-size requests.
module dmem_lsu #(
   parameter int unsigned N_Bits  = 32,
   parameter int unsigned Depth   = 256,
   parameter int unsigned Latency = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [N_Bits-1:0] A,
   input  logic [N_Bits-1:0] WD,
   output logic              rsp_valid,
   output logic [N_Bits-1:0] RD,
   output logic              rsp_err
);
   localparam int unsigned IDX_W = $clog2(Depth);
   localparam int unsigned CNT_W = 2;
   localparam int unsigned LANES = N_Bits / 8;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              rsp_valid_n;
   logic              accept;
   logic              err;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        lane;
   logic [N_Bits-1:0] word, wdata, load_data;
   logic [LANES-1:0]  be;
   logic [7:0]        sel_b;
   logic [15:0]       sel_h;
   logic [N_Bits-1:0] mem [Depth];
   logic              unused_addr;

   // Upper address bits are dropped so the address space wraps modulo Depth*4.
   assign idx         = A[IDX_W+1:2];
   assign lane        = A[1:0];
   assign unused_addr = ^A[N_Bits-1:IDX_W+2];
   assign accept      = req_valid && req_ready && (state == S_IDLE) && !rst;

   // Request decode: error check, byte enables, replicated store data, extended load data.
   always_comb begin
      err       = 1'b0;
      be        = '0;
      wdata     = WD;
      load_data = '0;
      word      = mem[idx];
      sel_b     = word[{lane, 3'b000} +: 8];
      sel_h     = lane[1] ? word[31:16] : word[15:0];
      case (req_size)
         2'b00: begin
            be        = LANES'(1) << lane;
            wdata     = {4{WD[7:0]}};
            load_data = {{(N_Bits-8){~req_unsigned & sel_b[7]}}, sel_b};
         end
         2'b01: begin
            err       = lane[0];
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{WD[15:0]}};
            load_data = {{(N_Bits-16){~req_unsigned & sel_h[15]}}, sel_h};
         end
         2'b10: begin
            err       = (lane != 2'b00);
            be        = '1;
            load_data = word;
         end
         default: err = 1'b1;
      endcase
      if (err) be = '0;
      if (err || req_we) load_data = '0;
   end

   // Store commits on the accept edge; contents are never reset.
   always_ff @(posedge clk) begin
      if (accept && req_we) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Next state; rsp_valid is raised one edge early so it lands in the last WAIT cycle.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      rsp_valid_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_n     = S_WAIT;
               cnt_n       = CNT_W'(Latency - 1);
               rsp_valid_n = (Latency == 1);
            end
         end
         S_WAIT: begin
            if (cnt != '0) begin
               cnt_n       = cnt - CNT_W'(1);
               rsp_valid_n = (cnt == CNT_W'(1));
            end else begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         RD        <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         req_ready <= (state_n == S_IDLE);
         rsp_valid <= rsp_valid_n;
         if (accept) begin
            RD      <= load_data;
            rsp_err <= err;
         end
      end
   end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (Latency 1, 3, 4) share every input and are
// checked against a byte-array memory model and the latency/handshake rules.
module tb_dmem_lsu;
   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       A;
   logic [31:0]       WD;
   logic [2:0]        rdy, rv, er;
   logic [2:0][31:0]  rdd;

   localparam logic [2:0][3:0] LATS = {4'd4, 4'd3, 4'd1};
   localparam int unsigned     SPAN = 1024;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] mdl [SPAN];

   always #5 clk = ~clk;

   dmem_lsu #(.N_Bits(32), .Depth(256), .Latency(1)) u_l1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .A(A), .WD(WD),
      .rsp_valid(rv[0]), .RD(rdd[0]), .rsp_err(er[0]));
   dmem_lsu #(.N_Bits(32), .Depth(256), .Latency(3)) u_l3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .A(A), .WD(WD),
      .rsp_valid(rv[1]), .RD(rdd[1]), .rsp_err(er[1]));
   dmem_lsu #(.N_Bits(32), .Depth(256), .Latency(4)) u_l4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .A(A), .WD(WD),
      .rsp_valid(rv[2]), .RD(rdd[2]), .rsp_err(er[2]));

   function automatic logic model_err(input logic [1:0] size, input logic [31:0] a);
      int n;
      n = 1 << size;
      return (size == 2'd3) || ((a % n) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] a);
      logic [31:0] v;
      int n;
      n = 1 << size;
      v = '0;
      for (int b = 0; b < n; b++) v = v | (32'(mdl[(a + b) % SPAN]) << (8 * b));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic model_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
      int n;
      n = 1 << size;
      for (int b = 0; b < n; b++) mdl[(a + b) % SPAN] = 8'(wd >> (8 * b));
   endtask

   // Issue one request to all instances and observe each response window.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [2:0][31:0] rd, output logic [2:0] err,
                        output logic [2:0][3:0] lat, output logic [2:0][3:0] low,
                        output logic [2:0][3:0] np);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; A = a; WD = wd;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      A = $urandom; WD = $urandom;
      rd = '0; err = '0; lat = '0; low = '0; np = '0;
      for (int k = 1; k <= 8; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (rv[i]) begin
               np[i] = np[i] + 4'd1;
               if (lat[i] == 4'd0) begin
                  lat[i] = 4'(k); rd[i] = rdd[i]; err[i] = er[i];
               end
            end
            if (!rdy[i]) low[i] = low[i] + 4'd1;
         end
         if (k < 8) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      A = '0; WD = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks += 4;
         if (rdy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ready inst=%0d got=%b exp=0", i, rdy[i]); end
         if (rv[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid inst=%0d got=%b exp=0", i, rv[i]); end
         if (er[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err inst=%0d got=%b exp=0", i, er[i]); end
         if (rdd[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rd inst=%0d got=%h exp=0", i, rdd[i]); end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL idle_ready inst=%0d got=%b exp=1", i, rdy[i]); end
      end
   endtask

   task automatic test_fill();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      logic [31:0] d;
      for (int w = 0; w < 16; w++) begin
         d = $urandom;
         issue(1'b1, 2'd2, 1'b0, 32'(w * 4), d, rd, err, lat, low, np);
         model_store(2'd2, 32'(w * 4), d);
         for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (lat[i] !== LATS[i]) begin n_fail++; $display("FAIL fill_latency inst=%0d got=%0d exp=%0d", i, lat[i], LATS[i]); end
            if (rd[i] !== 32'h0 || err[i] !== 1'b0) begin n_fail++; $display("FAIL fill_rsp inst=%0d got=%h/%b exp=0/0", i, rd[i], err[i]); end
         end
      end
   endtask

   task automatic test_word();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, low, np);
      model_store(2'd2, 32'h10, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) begin
         n_checks += 3;
         if (lat[i] !== LATS[i]) begin n_fail++; $display("FAIL word_store_latency inst=%0d got=%0d exp=%0d", i, lat[i], LATS[i]); end
         if (err[i] !== 1'b0) begin n_fail++; $display("FAIL word_store_err inst=%0d got=%b exp=0", i, err[i]); end
         if (np[i] !== 4'd1) begin n_fail++; $display("FAIL word_store_pulses inst=%0d got=%0d exp=1", i, np[i]); end
      end
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks += 3;
         if (rd[i] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load_data inst=%0d got=%h exp=deadbeef", i, rd[i]); end
         if (low[i] !== LATS[i]) begin n_fail++; $display("FAIL word_ready_low inst=%0d got=%0d exp=%0d", i, low[i], LATS[i]); end
         if (lat[i] !== LATS[i]) begin n_fail++; $display("FAIL word_load_latency inst=%0d got=%0d exp=%0d", i, lat[i], LATS[i]); end
      end
   endtask

   task automatic test_byte_half();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      logic [31:0] exp_v [4];
      logic [1:0]  sz    [4];
      logic        un    [4];
      logic [31:0] ad    [4];
      exp_v = '{32'h11228044, 32'hFFFFFF80, 32'h00000080, 32'h00001122};
      sz    = '{2'd2, 2'd0, 2'd0, 2'd1};
      un    = '{1'b0, 1'b0, 1'b1, 1'b0};
      ad    = '{32'h20, 32'h21, 32'h21, 32'h22};
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, err, lat, low, np);
      model_store(2'd2, 32'h20, 32'h11223344);
      issue(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF80, rd, err, lat, low, np);
      model_store(2'd0, 32'h21, 32'hFFFFFF80);
      for (int t = 0; t < 4; t++) begin
         issue(1'b0, sz[t], un[t], ad[t], 32'h0, rd, err, lat, low, np);
         for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (rd[i] !== exp_v[t]) begin n_fail++; $display("FAIL subword_load%0d inst=%0d got=%h exp=%h", t, i, rd[i], exp_v[t]); end
            if (err[i] !== 1'b0) begin n_fail++; $display("FAIL subword_err%0d inst=%0d got=%b exp=0", t, i, err[i]); end
         end
      end
   endtask

   task automatic test_errors();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h01020304, rd, err, lat, low, np);
      model_store(2'd2, 32'h0, 32'h01020304);
      issue(1'b1, 2'd1, 1'b0, 32'h3, 32'hBEEF, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks += 2;
         if (err[i] !== 1'b1) begin n_fail++; $display("FAIL half_misaligned_err inst=%0d got=%b exp=1", i, err[i]); end
         if (lat[i] !== LATS[i]) begin n_fail++; $display("FAIL err_latency inst=%0d got=%0d exp=%0d", i, lat[i], LATS[i]); end
      end
      issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd[i] !== 32'h01020304) begin n_fail++; $display("FAIL err_no_write inst=%0d got=%h exp=01020304", i, rd[i]); end
      end
      issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks += 2;
         if (err[i] !== 1'b1) begin n_fail++; $display("FAIL word_misaligned_err inst=%0d got=%b exp=1", i, err[i]); end
         if (rd[i] !== 32'h0) begin n_fail++; $display("FAIL word_misaligned_rd inst=%0d got=%h exp=0", i, rd[i]); end
      end
      issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks += 2;
         if (err[i] !== 1'b1) begin n_fail++; $display("FAIL illegal_size_err inst=%0d got=%b exp=1", i, err[i]); end
         if (rd[i] !== 32'h0) begin n_fail++; $display("FAIL illegal_size_rd inst=%0d got=%h exp=0", i, rd[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5A5A5, rd, err, lat, low, np);
      model_store(2'd2, 32'h400, 32'hA5A5A5A5);
      issue(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd[i] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wrap_load inst=%0d got=%h exp=a5a5a5a5", i, rd[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int rsp[$];
      logic [31:0] exp_v;
      exp_v = model_load(2'd2, 1'b0, 32'h10);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; A = 32'h10;
      for (int c = 0; c <= 14; c++) begin
         if (c > 0) @(negedge clk);
         if (rv[2]) begin
            rsp.push_back(c);
            n_checks++;
            if (rdd[2] !== exp_v) begin n_fail++; $display("FAIL b2b_data cycle=%0d got=%h exp=%h", c, rdd[2], exp_v); end
         end
         if (rdy[2]) acc.push_back(c);
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (acc.size() < 3 || rsp.size() < 3) begin
         n_fail++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", acc.size(), rsp.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (rsp[j] - acc[j] != 4) begin n_fail++; $display("FAIL b2b_latency idx=%0d got=%0d exp=4", j, rsp[j] - acc[j]); end
         end
         for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (acc[j+1] - acc[j] != 5) begin n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=5", j, acc[j+1] - acc[j]); end
         end
      end
   endtask

   task automatic test_reset_inflight();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      int seen;
      logic [31:0] d, old_v;
      // In-flight load is dropped by reset.
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; A = 32'h10;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      if (rv[1]) seen++;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL rst_cycle_ready got=%b exp=0", rdy[1]); end
      @(negedge clk);
      n_checks++;
      if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b exp=1", rdy[1]); end
      for (int k = 0; k < 6; k++) begin
         if (rv[1]) seen++;
         @(negedge clk);
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL rst_no_rsp got=%0d exp=0", seen); end
      // In-flight store stays committed.
      d = $urandom;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; A = 32'h14; WD = d;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      model_store(2'd2, 32'h14, d);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd[i] !== d) begin n_fail++; $display("FAIL rst_store_kept inst=%0d got=%h exp=%h", i, rd[i], d); end
      end
      // Reset wins over a simultaneous request.
      old_v = model_load(2'd2, 1'b0, 32'h18);
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; A = 32'h18; WD = ~old_v;
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      repeat (2) @(negedge clk);
      issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, rd, err, lat, low, np);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd[i] !== old_v) begin n_fail++; $display("FAIL rst_blocks_write inst=%0d got=%h exp=%h", i, rd[i], old_v); end
      end
   endtask

   task automatic test_random();
      logic [2:0][31:0] rd; logic [2:0] err; logic [2:0][3:0] lat, low, np;
      logic        we, uns, e_err;
      logic [1:0]  size;
      logic [31:0] a, d, e_rd;
      for (int t = 0; t < 40; t++) begin
         we   = 1'($urandom);
         uns  = 1'($urandom);
         size = 2'($urandom);
         a    = 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3) * 32'h400);
         d    = $urandom;
         e_err = model_err(size, a);
         e_rd  = (e_err || we) ? 32'h0 : model_load(size, uns, a);
         issue(we, size, uns, a, d, rd, err, lat, low, np);
         if (we && !e_err) model_store(size, a, d);
         for (int i = 0; i < 3; i++) begin
            n_checks += 3;
            if (rd[i] !== e_rd) begin n_fail++; $display("FAIL rand_rd t=%0d inst=%0d a=%h sz=%0d got=%h exp=%h", t, i, a, size, rd[i], e_rd); end
            if (err[i] !== e_err) begin n_fail++; $display("FAIL rand_err t=%0d inst=%0d got=%b exp=%b", t, i, err[i], e_err); end
            if (lat[i] !== LATS[i]) begin n_fail++; $display("FAIL rand_latency t=%0d inst=%0d got=%0d exp=%0d", t, i, lat[i], LATS[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_word();
      test_byte_half();
      test_errors();
      test_wrap();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
